// File: rtl/demux_pkg.sv
// Shared constants and routing helpers for the 1-to-2 demux dispatch path.
// Holds the default geometry, the mode encodings and the route-select rule.
package demux_pkg;

  localparam int DMX_WIDTH = 16;
  localparam int DMX_DEPTH = 4;
  localparam int CNT_W     = 16;

  typedef enum logic {
    MODE_RR  = 1'b0,
    MODE_BIT = 1'b1
  } dmx_mode_e;

  // Channel choice: alternate in round-robin mode, otherwise follow the head MSB.
  function automatic logic route_sel(input dmx_mode_e m, input logic rr, input logic msb);
    logic sel;
    sel = rr;
    if (m == MODE_BIT) begin
      sel = msb;
    end
    return sel;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and an explicit occupancy count.
// Storage is not reset; only pointers and count are cleared by rst.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Overflowing pushes and underflowing pops are ignored rather than corrupting state.
  assign wr_en = push && !full;
  assign rd_en = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Buffers upstream words and dispatches the FIFO head to one of two demux
// channels, either alternating or by the head MSB, counting words per channel.
module demux_dispatch_ctrl
  import demux_pkg::*;
#(
  parameter int WIDTH = DMX_WIDTH,
  parameter int DEPTH = DMX_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic             dst_ready0,
  input  logic             dst_ready1,
  output logic [WIDTH-1:0] dmx_data,
  output logic             dmx_sel,
  output logic             dmx_valid,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic             fifo_full;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_head;
  logic             push;
  logic             pop;
  logic             rr_ptr;
  dmx_mode_e        mode_e;

  assign mode_e = dmx_mode_e'(mode);

  // in_ready looks only at full, so a pop never opens a slot in the same cycle.
  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;

  assign dmx_valid = !fifo_empty;
  assign dmx_data  = fifo_head;
  assign dmx_sel   = route_sel(mode_e, rr_ptr, fifo_head[WIDTH-1]);

  assign pop = dmx_valid && (dmx_sel ? dst_ready1 : dst_ready0);

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .head    (fifo_head)
  );

  // rr_ptr advances only on dispatches made in round-robin mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (pop && (mode_e == MODE_RR)) begin
      rr_ptr <= ~rr_ptr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (pop) begin
      if (dmx_sel) begin
        cnt1 <= cnt1 + CNT_ONE;
      end else begin
        cnt0 <= cnt0 + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Bench for demux_dispatch_ctrl: queue-based reference model compared every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_demux_dispatch_ctrl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             mode = 1'b0;
  logic             dst_ready0 = 1'b0;
  logic             dst_ready1 = 1'b0;
  logic [WIDTH-1:0] dmx_data;
  logic             dmx_sel;
  logic             dmx_valid;
  logic [15:0]      cnt0;
  logic [15:0]      cnt1;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  demux_dispatch_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode       (mode),
    .dst_ready0 (dst_ready0),
    .dst_ready1 (dst_ready1),
    .dmx_data   (dmx_data),
    .dmx_sel    (dmx_sel),
    .dmx_valid  (dmx_valid),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a word queue plus per-channel tallies.
  logic [WIDTH-1:0] mq[$];
  bit               m_rr = 1'b0;
  logic [15:0]      m_c0 = '0;
  logic [15:0]      m_c1 = '0;

  function automatic bit model_sel();
    if (mode) return mq[0][WIDTH-1];
    return m_rr;
  endfunction

  always @(posedge clk) begin
    bit do_push;
    bit do_pop;
    bit sel;
    if (rst) begin
      mq.delete();
      m_rr = 1'b0;
      m_c0 = '0;
      m_c1 = '0;
    end else begin
      do_push = in_valid && (mq.size() < DEPTH);
      do_pop  = 1'b0;
      sel     = 1'b0;
      if (mq.size() > 0) begin
        sel    = model_sel();
        do_pop = sel ? dst_ready1 : dst_ready0;
      end
      if (do_pop) begin
        void'(mq.pop_front());
        if (sel) m_c1 = m_c1 + 16'd1;
        else     m_c0 = m_c0 + 16'd1;
        if (!mode) m_rr = ~m_rr;
      end
      if (do_push) mq.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("model_in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("model_dmx_valid", 32'(dmx_valid), 32'(mq.size() > 0));
      chk("model_cnt0", 32'(cnt0), 32'(m_c0));
      chk("model_cnt1", 32'(cnt1), 32'(m_c1));
      if (mq.size() > 0) begin
        chk("model_dmx_data", 32'(dmx_data), 32'(mq[0]));
        chk("model_dmx_sel", 32'(dmx_sel), 32'(model_sel()));
      end else if (!mode) begin
        chk("model_sel_empty_rr", 32'(dmx_sel), 32'(m_rr));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [WIDTH-1:0] got[5];
  int               ndisp;
  bit               taken;

  initial begin
    // Reset state
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_dmx_valid", 32'(dmx_valid), 32'd0);
    chk("rst_dmx_sel", 32'(dmx_sel), 32'd0);
    chk("rst_cnt0", 32'(cnt0), 32'd0);
    chk("rst_cnt1", 32'(cnt1), 32'd0);
    check_en = 1'b1;

    // Round-robin: 1..4 go out on sel 0,1,0,1
    mode = 1'b0; dst_ready0 = 1'b1; dst_ready1 = 1'b1;
    chk("rr_no_early_valid", 32'(dmx_valid), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_data  = 16'(k);
      step();
      chk("rr_valid", 32'(dmx_valid), 32'd1);
      chk("rr_data", 32'(dmx_data), 32'(k));
      chk("rr_sel", 32'(dmx_sel), 32'((k - 1) % 2));
    end
    in_valid = 1'b0;
    step();
    chk("rr_cnt0", 32'(cnt0), 32'd2);
    chk("rr_cnt1", 32'(cnt1), 32'd2);
    chk("rr_drained", 32'(dmx_valid), 32'd0);

    // Bit routing: 8001,0002,8003 -> sel 1,0,1
    do_reset();
    mode = 1'b1;
    begin
      logic [15:0] words[3];
      logic        sels[3];
      words = '{16'h8001, 16'h0002, 16'h8003};
      sels  = '{1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 3; k++) begin
        in_valid = 1'b1;
        in_data  = words[k];
        step();
        chk("bit_data", 32'(dmx_data), 32'(words[k]));
        chk("bit_sel", 32'(dmx_sel), 32'(sels[k]));
      end
    end
    in_valid = 1'b0;
    step();
    chk("bit_cnt0", 32'(cnt0), 32'd1);
    chk("bit_cnt1", 32'(cnt1), 32'd2);

    // Full and backpressure: 5th word held upstream, then all 5 out in order
    do_reset();
    mode = 1'b0; dst_ready0 = 1'b0; dst_ready1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_data  = 16'h0A00 + 16'(k);
      step();
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_data = 16'h0A05;
    step();
    step();
    chk("full_hold_ready", 32'(in_ready), 32'd0);
    chk("full_head", 32'(dmx_data), 32'h0A01);
    dst_ready0 = 1'b1; dst_ready1 = 1'b1;
    ndisp = 0;
    for (int cyc = 0; cyc < 20 && ndisp < 5; cyc++) begin
      taken = in_valid && in_ready;
      if (dmx_valid && (dmx_sel ? dst_ready1 : dst_ready0)) begin
        got[ndisp] = dmx_data;
        ndisp++;
      end
      step();
      if (taken) in_valid = 1'b0;
    end
    chk("full_disp_count", 32'(ndisp), 32'd5);
    for (int k = 0; k < 5; k++) begin
      chk("full_order", 32'(got[k]), 32'h0A01 + 32'(k));
    end

    // Per-channel stall: head 8000 waits on channel 1 only
    do_reset();
    mode = 1'b1; dst_ready0 = 1'b1; dst_ready1 = 1'b0;
    in_valid = 1'b1; in_data = 16'h8000;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("stall_valid", 32'(dmx_valid), 32'd1);
      chk("stall_sel", 32'(dmx_sel), 32'd1);
      chk("stall_data", 32'(dmx_data), 32'h8000);
      chk("stall_cnt0", 32'(cnt0), 32'd0);
      step();
    end
    dst_ready1 = 1'b1;
    step();
    chk("stall_cnt1", 32'(cnt1), 32'd1);
    chk("stall_empty", 32'(dmx_valid), 32'd0);

    // Reset mid-stream with 3 words buffered and cnt0 nonzero
    do_reset();
    mode = 1'b0; dst_ready0 = 1'b0; dst_ready1 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1;
      in_data  = 16'h0C00 + 16'(k);
      step();
    end
    in_valid = 1'b0;
    dst_ready0 = 1'b1;
    step();
    dst_ready0 = 1'b0;
    chk("mid_cnt0_before", 32'(cnt0), 32'd1);
    rst = 1'b1; in_valid = 1'b1; in_data = 16'h0CFF;
    dst_ready0 = 1'b1; dst_ready1 = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_valid", 32'(dmx_valid), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_cnt0", 32'(cnt0), 32'd0);
    chk("mid_cnt1", 32'(cnt1), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("mid_no_stale", 32'(dmx_valid), 32'd0);
    end

    // Randomized traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_data    = 16'($urandom);
      dst_ready0 = ($urandom_range(0, 2) != 0);
      dst_ready1 = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0; in_valid = 1'b0; dst_ready0 = 1'b1; dst_ready1 = 1'b1;
    for (int k = 0; k < 8; k++) step();
    chk("rand_drained", 32'(dmx_valid), 32'd0);

    // Counter wrap: 65535 channel-0 dispatches, then one more
    do_reset();
    mode = 1'b1; dst_ready0 = 1'b1; dst_ready1 = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 65535; k++) begin
      in_data = 16'($urandom) & 16'h7FFF;
      step();
    end
    in_valid = 1'b0;
    step();
    chk("wrap_cnt0_max", 32'(cnt0), 32'h0000FFFF);
    in_valid = 1'b1; in_data = 16'h0123;
    step();
    in_valid = 1'b0;
    step();
    chk("wrap_cnt0_zero", 32'(cnt0), 32'd0);
    chk("wrap_cnt1", 32'(cnt1), 32'd0);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_dispatch_ctrl.md
DEMUX_DISPATCH_CTRL -- requirements
Module: demux_dispatch_ctrl

Interface
REQ-001 Parameter WIDTH, default 16: data word width, equal to the 16-bit demux data path.
REQ-002 Parameter DEPTH, default 4: FIFO entries; the value SHALL be a power of two and at least 2.
REQ-003 The block SHALL use one clock, and its reset SHALL be synchronous and active-high. The clock port SHALL be clk and the reset port SHALL be rst.
REQ-004 The ports SHALL be as follows (clock and reset first):
  clk         in   1      rising-edge clock
  rst         in   1      synchronous active-high reset
  in_data     in   WIDTH  upstream word
  in_valid    in   1      upstream word valid
  in_ready    out  1      block can accept a word
  mode        in   1      routing: 0 = round-robin, 1 = route by head bit WIDTH-1
  dst_ready0  in   1      channel 0 consumer ready
  dst_ready1  in   1      channel 1 consumer ready
  dmx_data    out  WIDTH  word to the demux data_in
  dmx_sel     out  1      demux sel (0 = out0, 1 = out1)
  dmx_valid   out  1      dmx_data/dmx_sel hold a word
  cnt0        out  16     words dispatched to channel 0
  cnt1        out  16     words dispatched to channel 1

Function
REQ-005 Push SHALL occur on a rising edge when in_valid && in_ready; the word enters the FIFO tail.
REQ-006 in_ready SHALL equal !full, with no dependence on the pop in the same cycle (no full-bypass).
REQ-007 dmx_valid SHALL equal !empty, and dmx_data SHALL equal the FIFO head word.
REQ-008 There SHALL be no empty pass-through: a word pushed at edge N SHALL appear on dmx_valid/dmx_data after edge N, never earlier.
REQ-009 When mode=0, dmx_sel SHALL equal rr_ptr; when mode=1, dmx_sel SHALL equal dmx_data[WIDTH-1].
REQ-010 dmx_sel SHALL be combinational from mode, rr_ptr and the head word; a mode change SHALL take effect in the same cycle.
REQ-011 Pop (dispatch) SHALL occur when dmx_valid && (dmx_sel ? dst_ready1 : dst_ready0).
REQ-012 A stalled head SHALL hold dmx_data and dmx_sel stable while mode is constant, and SHALL NOT block on the ready of the other channel.
REQ-013 rr_ptr SHALL toggle on each dispatch while mode=0, and SHALL hold its value while mode=1.
REQ-014 Simultaneous push and pop when neither full nor empty SHALL leave the occupancy unchanged.
REQ-015 Simultaneous push and pop with one entry stored SHALL dispatch the old head; the new word becomes head on the next cycle.
REQ-016 Read and write pointers SHALL wrap modulo DEPTH, and occupancy SHALL be tracked with a count of log2(DEPTH)+1 bits.
REQ-017 cnt0 SHALL increment by 1 on each dispatch with dmx_sel=0, and cnt1 SHALL increment by 1 on each dispatch with dmx_sel=1.
REQ-018 Both counters SHALL wrap from 16'hFFFF to 0 without a flag.
REQ-019 The block SHALL NOT drop words: every pushed word SHALL be dispatched exactly once, in order.

Reset
REQ-020 While rst=1 at a rising edge, the block SHALL clear the FIFO pointers and count, rr_ptr, cnt0 and cnt1 to 0.
REQ-021 After reset, in_ready SHALL be 1, dmx_valid SHALL be 0, and dmx_sel SHALL be 0 in mode 0.
REQ-022 When reset is applied mid-operation, all buffered words SHALL be discarded, and no dispatch or push SHALL occur in the reset cycle.
REQ-023 FIFO storage contents SHALL NOT require reset; dmx_data while dmx_valid=0 is don't-care.

Structure
REQ-024 Constants DMX_WIDTH=16 and DMX_DEPTH=4, and the mode encodings MODE_RR=0 and MODE_BIT=1, SHALL reside in a shared package demux_pkg.
REQ-025 Storage SHALL be one sub-module, sync_fifo, with push, pop, full, empty and head outputs.
REQ-026 The routing logic and the counters SHALL reside in demux_dispatch_ctrl.
REQ-027 The outputs dmx_data and dmx_sel SHALL drive demux_1to2_16bit directly.

Verification
REQ-028 Round-robin: mode=0, both readies 1, push 16'h0001..16'h0004 on consecutive cycles -> dmx_sel sequence 0,1,0,1; cnt0=2, cnt1=2; first dmx_valid one cycle after the first push.
REQ-029 Bit routing: mode=1, push 16'h8001, 16'h0002, 16'h8003 -> dmx_sel sequence 1,0,1; cnt1=2, cnt0=1.
REQ-030 Full and backpressure: both readies 0, push 5 words -> in_ready=0 after 4 pushes and the 5th word held upstream; then dst_ready0=dst_ready1=1 -> all 5 words out in order.
REQ-031 Per-channel stall: mode=1, head 16'h8000, dst_ready1=0, dst_ready0=1 -> dmx_valid=1 and dmx_sel=1 stable, and cnt0 unchanged until dst_ready1=1.
REQ-032 Reset mid-stream: 3 words buffered, assert rst for one cycle -> dmx_valid=0, in_ready=1, cnt0=cnt1=0, and no stale word appears afterwards.
REQ-033 Counter wrap: preload 65535 dispatches to channel 0 (or force cnt0=16'hFFFF), then one more dispatch to channel 0 -> cnt0=0.
